// File: rtl/jtag_tap_ir.sv
// jtag_tap_ir: IEEE 1149.1-style TAP controller with integrated instruction register.
// Optional macro IR_CAPTURE_STATUS_EN: CapIR loads {status_in, 2'b01} instead of {0, 2'b01}.
module jtag_tap_ir #(
    parameter int                     IR_WIDTH   = 4,
    parameter logic [IR_WIDTH-1:0]    RESET_INST = {IR_WIDTH{1'b1}}
) (
    input  logic                  TCK,
    input  logic                  TRST,
    input  logic                  TMS,
    input  logic                  TDI,
    input  logic                  dr_tdo,
    input  logic [IR_WIDTH-3:0]   status_in,
    output logic                  TDO,
    output logic                  tdo_en,
    output logic [IR_WIDTH-1:0]   inst,
    output logic                  bypass_sel,
    output logic [3:0]            tap_state,
    output logic                  capture_dr,
    output logic                  shift_dr,
    output logic                  update_dr,
    output logic                  tlr
);

    typedef enum logic [3:0] {
        S_TLR     = 4'hF,
        S_RTI     = 4'hC,
        S_SEL_DR  = 4'h7,
        S_CAP_DR  = 4'h6,
        S_SH_DR   = 4'h2,
        S_EX1_DR  = 4'h1,
        S_PAU_DR  = 4'h3,
        S_EX2_DR  = 4'h0,
        S_UPD_DR  = 4'h5,
        S_SEL_IR  = 4'h4,
        S_CAP_IR  = 4'hE,
        S_SH_IR   = 4'hA,
        S_EX1_IR  = 4'h9,
        S_PAU_IR  = 4'hB,
        S_EX2_IR  = 4'h8,
        S_UPD_IR  = 4'hD
    } tap_state_e;

    tap_state_e           state_q;
    tap_state_e           state_d;
    logic [IR_WIDTH-1:0]  sr_q;
    logic [IR_WIDTH-1:0]  cap_val;

`ifdef IR_CAPTURE_STATUS_EN
    assign cap_val = {status_in, 2'b01};
`else
    // status_in is present on the port but has no function in this build
    logic unused_status;
    assign unused_status = ^status_in;
    assign cap_val = {{(IR_WIDTH-2){1'b0}}, 2'b01};
`endif

    // Next-state decode of the 16-state TAP graph on TMS
    always_comb begin
        state_d = S_TLR;
        unique case (state_q)
            S_TLR:    state_d = TMS ? S_TLR    : S_RTI;
            S_RTI:    state_d = TMS ? S_SEL_DR : S_RTI;
            S_SEL_DR: state_d = TMS ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: state_d = TMS ? S_EX1_DR : S_SH_DR;
            S_SH_DR:  state_d = TMS ? S_EX1_DR : S_SH_DR;
            S_EX1_DR: state_d = TMS ? S_UPD_DR : S_PAU_DR;
            S_PAU_DR: state_d = TMS ? S_EX2_DR : S_PAU_DR;
            S_EX2_DR: state_d = TMS ? S_UPD_DR : S_SH_DR;
            S_UPD_DR: state_d = TMS ? S_SEL_DR : S_RTI;
            S_SEL_IR: state_d = TMS ? S_TLR    : S_CAP_IR;
            S_CAP_IR: state_d = TMS ? S_EX1_IR : S_SH_IR;
            S_SH_IR:  state_d = TMS ? S_EX1_IR : S_SH_IR;
            S_EX1_IR: state_d = TMS ? S_UPD_IR : S_PAU_IR;
            S_PAU_IR: state_d = TMS ? S_EX2_IR : S_PAU_IR;
            S_EX2_IR: state_d = TMS ? S_UPD_IR : S_SH_IR;
            S_UPD_IR: state_d = TMS ? S_SEL_DR : S_RTI;
            default:  state_d = S_TLR;
        endcase
    end

    // TAP state, IR shift register and latched instruction
    always_ff @(posedge TCK) begin
        if (TRST) begin
            state_q <= S_TLR;
            sr_q    <= cap_val;
            inst    <= RESET_INST;
        end else begin
            state_q <= state_d;
            if (state_q == S_CAP_IR) begin
                sr_q <= cap_val;
            end else if (state_q == S_SH_IR) begin
                sr_q <= {TDI, sr_q[IR_WIDTH-1:1]};
            end
            // entering or sitting in TLR forces the reset instruction
            if (state_q == S_TLR || state_d == S_TLR) begin
                inst <= RESET_INST;
            end else if (state_q == S_UPD_IR) begin
                inst <= sr_q;
            end
        end
    end

    // Output decodes of the registered state
    always_comb begin
        tap_state  = state_q;
        tlr        = (state_q == S_TLR);
        capture_dr = (state_q == S_CAP_DR);
        shift_dr   = (state_q == S_SH_DR);
        update_dr  = (state_q == S_UPD_DR);
        tdo_en     = (state_q == S_SH_IR) || (state_q == S_SH_DR);
        bypass_sel = (inst == {IR_WIDTH{1'b1}});
        TDO        = 1'b0;
        if (state_q == S_SH_IR) begin
            TDO = sr_q[0];
        end else if (state_q == S_SH_DR) begin
            TDO = dr_tdo;
        end
    end

endmodule

// File: tb/tb_jtag_tap_ir.sv
// tb_jtag_tap_ir: randomized and directed checks of jtag_tap_ir against a
// table-driven TAP model with an integer shift-register model.
module tb_jtag_tap_ir;

    localparam int W = 4;

    logic          TCK = 1'b0;
    logic          TRST = 1'b0;
    logic          TMS = 1'b0;
    logic          TDI = 1'b0;
    logic          dr_tdo = 1'b0;
    logic [W-3:0]  status_in = '0;
    logic          TDO;
    logic          tdo_en;
    logic [W-1:0]  inst;
    logic          bypass_sel;
    logic [3:0]    tap_state;
    logic          capture_dr;
    logic          shift_dr;
    logic          update_dr;
    logic          tlr;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    int        t0 [16];
    int        t1 [16];
    int        ms = 15;
    int        msr = 0;
    int        minst = 15;
    bit        seen [$];
    int        ones_run = 0;

    jtag_tap_ir #(.IR_WIDTH(W)) dut (
        .TCK        (TCK),
        .TRST       (TRST),
        .TMS        (TMS),
        .TDI        (TDI),
        .dr_tdo     (dr_tdo),
        .status_in  (status_in),
        .TDO        (TDO),
        .tdo_en     (tdo_en),
        .inst       (inst),
        .bypass_sel (bypass_sel),
        .tap_state  (tap_state),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .tlr        (tlr)
    );

    always #5 TCK = ~TCK;

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic int cap_val();
`ifdef IR_CAPTURE_STATUS_EN
        return int'(status_in) * 4 + 1;
`else
        return 1;
`endif
    endfunction

    // Drive one TCK cycle and advance the model by the same edge
    task automatic step(bit t, bit m, bit d, bit r);
        int nx;
        TRST = t;
        TMS = m;
        TDI = d;
        dr_tdo = r;
        nx = t ? 15 : (m ? t1[ms] : t0[ms]);
        @(posedge TCK);
        #1;
        if (t) begin
            msr = cap_val();
            minst = (1 << W) - 1;
        end else begin
            if (ms == 15 || nx == 15) minst = (1 << W) - 1;
            else if (ms == 13) minst = msr;
            if (ms == 14) msr = cap_val();
            else if (ms == 10) msr = (msr >> 1) + (int'(d) << (W - 1));
        end
        ms = nx;
        @(negedge TCK);
        #1;
    endtask

    // Every cycle: all outputs against the model
    always @(negedge TCK) begin
        if (cmp_en) begin
            chk("state", 32'(tap_state), 32'(ms));
            chk("inst", 32'(inst), 32'(minst));
            chk("bypass_sel", 32'(bypass_sel), 32'(minst == 15));
            chk("tdo", 32'(TDO),
                (ms == 10) ? 32'(msr % 2) : (ms == 2) ? 32'(dr_tdo) : 32'd0);
            chk("tdo_en", 32'(tdo_en), 32'(ms == 10 || ms == 2));
            chk("capture_dr", 32'(capture_dr), 32'(ms == 6));
            chk("shift_dr", 32'(shift_dr), 32'(ms == 2));
            chk("update_dr", 32'(update_dr), 32'(ms == 5));
            chk("tlr", 32'(tlr), 32'(ms == 15));
        end
    end

    task automatic to_shir();
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
    endtask

    initial begin
        bit [3:0] tms_v;
        bit [3:0] tdi_v;
        bit [3:0] exp6;
        t0 = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
        t1 = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

        // 1: reset
        step(1, 1'($urandom), 0, 0);
        step(1, 1'($urandom), 0, 0);
        cmp_en = 1'b1;
        chk("rst_state", 32'(tap_state), 32'hF);
        chk("rst_inst", 32'(inst), 32'hF);
        chk("rst_bypass", 32'(bypass_sel), 32'd1);
        chk("rst_tlr", 32'(tlr), 32'd1);
        chk("rst_tdo_en", 32'(tdo_en), 32'd0);
        chk("rst_tdo", 32'(TDO), 32'd0);

        // 2: load instruction 0011
        to_shir();
        chk("in_shir", 32'(tap_state), 32'hA);
        tms_v = 4'b1000;
        tdi_v = 4'b0011;
        seen.delete();
        for (int i = 0; i < 4; i++) begin
            seen.push_back(TDO);
            step(0, tms_v[i], tdi_v[i], 0);
        end
        chk("shift_tdo0", 32'(seen[0]), 32'd1);
        chk("shift_tdo1", 32'(seen[1]), 32'd0);
        chk("shift_tdo2", 32'(seen[2]), 32'd0);
        chk("shift_tdo3", 32'(seen[3]), 32'd0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("inst_0011", 32'(inst), 32'h3);
        chk("bypass_off", 32'(bypass_sel), 32'd0);

        // 3: park in ShDR with toggling dr_tdo
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 1'(i));
            chk("dr_tdo_track", 32'(TDO), 32'(i % 2));
            chk("shift_dr_hi", 32'(shift_dr), 32'd1);
        end
        chk("dr_inst_kept", 32'(inst), 32'h3);

        // 4: five TMS=1 from ShDR, then from PauseIR
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        chk("five_from_shdr", 32'(tap_state), 32'hF);
        chk("five_inst", 32'(inst), 32'hF);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("in_pauseir", 32'(tap_state), 32'hB);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        chk("five_from_pir", 32'(tap_state), 32'hF);

        // 5: TRST mid-shift, then fresh capture
        to_shir();
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        chk("trst_state", 32'(tap_state), 32'hF);
        chk("trst_inst", 32'(inst), 32'hF);
        to_shir();
        chk("recap_tdo0", 32'(TDO), 32'd1);
        step(0, 0, 0, 0);
        chk("recap_tdo1", 32'(TDO), 32'd0);

        // 6: capture with status_in = 10
        step(1, 0, 0, 0);
        status_in = 2'b10;
        to_shir();
        seen.delete();
        for (int i = 0; i < 4; i++) begin
            seen.push_back(TDO);
            step(0, (i == 3), 0, 0);
        end
`ifdef IR_CAPTURE_STATUS_EN
        exp6 = 4'b1001;
`else
        exp6 = 4'b0001;
`endif
        for (int i = 0; i < 4; i++)
            chk("status_cap", 32'(seen[i]), 32'(exp6[i]));

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            bit t;
            bit m;
            t = ($urandom_range(0, 60) == 0);
            m = ($urandom_range(0, 2) == 0);
            status_in = (W-2)'($urandom);
            step(t, m, 1'($urandom), 1'($urandom));
            ones_run = (t || m) ? ones_run + 1 : 0;
            if (ones_run >= 5)
                chk("five_ones_tlr", 32'(tap_state), 32'hF);
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jtag_tap_ir.md
Name: jtag_tap_ir

Overview:
Integrated IEEE 1149.1-style TAP controller and parametrised instruction register, clocked only by TCK. It takes over from the separate tapcontroller/IR pair. Adds a generic IR width, a 01 capture pattern, serial TDO muxing between the IR and an external data register, tdo_en, a bypass decode, and TMS-driven return to Test-Logic-Reset. It sits between the chip-level JTAG pins and the boundary-scan/bypass data registers.

Parameters:
IR_WIDTH, 4, instruction register length in bits; minimum 2.
RESET_INST, {IR_WIDTH{1'b1}}, instruction loaded on reset and while in Test-Logic-Reset (BYPASS).

Ports:
TCK  input  1  scan clock; all state updates on its rising edge
TRST  input  1  synchronous active-high reset
TMS  input  1  TAP mode select
TDI  input  1  serial data in
dr_tdo  input  1  serial out of the currently selected data register
status_in  input  IR_WIDTH-2  captured into IR upper bits (only with IR_CAPTURE_STATUS_EN)
TDO  output  1  serial data out
tdo_en  output  1  high while TDO is valid
inst  output  IR_WIDTH  current (updated) instruction
bypass_sel  output  1  inst == all ones
tap_state  output  4  current TAP state code
capture_dr, shift_dr, update_dr  output  1 each  high while in the matching DR state
tlr  output  1  high in Test-Logic-Reset

Behaviour:
- Reset is synchronous: TRST=1 at a TCK rising edge -> state TLR, shift register = capture value, inst = RESET_INST. All outputs are registered-state decodes. After reset: TDO=0, tdo_en=0, tlr=1, bypass_sel per RESET_INST, DR strobes 0.
- State codes: TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D.
- Standard 1149.1 transitions on TMS:
  - TLR: 1 stays, 0 -> RTI
  - RTI/UpdDR/UpdIR: 1 -> SelDR, 0 -> RTI
  - SelDR: 1 -> SelIR, 0 -> CapDR
  - SelIR: 1 -> TLR, 0 -> CapIR
  - Cap: 1 -> Ex1, 0 -> Sh
  - Sh: 0 stays, 1 -> Ex1
  - Ex1: 1 -> Upd, 0 -> Pause
  - Pause: 0 stays, 1 -> Ex2
  - Ex2: 1 -> Upd, 0 -> Sh
- Five consecutive TMS=1 edges reach TLR from any state.
- While in TLR, inst is forced to RESET_INST every edge.
- Edge leaving CapIR: sr <= {zeros, 2'b01}, with the LSB pair fixed at 01.
- Each edge while in ShIR, including the edge leaving it: sr <= {TDI, sr[IR_WIDTH-1:1]}, LSB first. Shifting N bits takes N edges in ShIR: TMS=0 for N-1 of them, TMS=1 on the last.
- PauseIR/Ex1IR/Ex2IR hold sr.
- Edge leaving UpdIR: inst <= sr. inst changes only at this edge, on TLR, or on reset.
- TDO is combinational:
  - ShIR: sr[0]
  - ShDR: dr_tdo
  - otherwise: 0
- tdo_en = ShIR or ShDR.
- TRST mid-shift: partial shift discarded, inst = RESET_INST, no update.
- TRST has priority over TMS in the same cycle.

Optional Feature:
IR_CAPTURE_STATUS_EN. When defined, CapIR loads {status_in, 2'b01}. When undefined, CapIR loads {zeros, 2'b01}; the status_in port still exists and is ignored.

Test Plan:
1. TRST=1 for 2 edges, any TMS -> tap_state=F, inst=4'hF, bypass_sel=1, tlr=1, tdo_en=0.
2. From RTI, TMS 1,1,0,0 -> CapIR then ShIR. Then TMS 0,0,0,1 with TDI 1,1,0,0, then TMS 1,0 -> TDO seen as 1,0,0,0 during the shift edges; inst=4'b0011 after leaving UpdIR; bypass_sel=0.
3. Park in ShDR with dr_tdo toggling -> TDO tracks dr_tdo, tdo_en=1, shift_dr=1; inst unchanged.
4. From ShDR, five TMS=1 edges -> TLR, inst=4'hF. Also from PauseIR -> TLR.
5. Assert TRST after 2 bits shifted in ShIR -> next state F, inst=4'hF; a fresh CapIR capture yields TDO 1 then 0.
6. With IR_CAPTURE_STATUS_EN and status_in=2'b10, capture and shift 4 bits -> TDO 1,0,0,1; without the macro -> 1,0,0,0.
